// File: rtl/cordic_bus_frontend_pkg.sv
// Shared definitions for the CORDIC bus front end: widths, register map, bit positions,
// FSM encoding and mode codes.
package cordic_bus_frontend_pkg;

    localparam int unsigned FIXED_WIDTH    = 16;
    localparam int unsigned SHIFT_W        = 4;
    localparam int unsigned TIMEOUT_CYCLES = 64;
    localparam int unsigned ADDR_W         = 6;
    localparam int unsigned DATA_W         = 32;

    localparam logic [ADDR_W-1:0] OFS_OPA    = 6'h00;
    localparam logic [ADDR_W-1:0] OFS_OPB    = 6'h04;
    localparam logic [ADDR_W-1:0] OFS_CTRL   = 6'h08;
    localparam logic [ADDR_W-1:0] OFS_STATUS = 6'h0C;
    localparam logic [ADDR_W-1:0] OFS_RES1   = 6'h10;
    localparam logic [ADDR_W-1:0] OFS_RES2   = 6'h14;

    localparam int unsigned CTRL_GO       = 0;
    localparam int unsigned CTRL_ROT      = 1;
    localparam int unsigned CTRL_MODE_LO  = 2;
    localparam int unsigned CTRL_SHIFT_LO = 4;
    localparam int unsigned CTRL_IRQ_EN   = 8;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_VALID    = 1;
    localparam int unsigned STAT_OVERRUN  = 2;
    localparam int unsigned STAT_IRQ_PEND = 3;
    localparam int unsigned STAT_TIMEOUT  = 4;

    typedef enum logic [1:0] {
        MODE_CIRCULAR   = 2'b00,
        MODE_LINEAR     = 2'b01,
        MODE_HYPERBOLIC = 2'b10
    } cordic_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b10
    } fe_state_e;

    // Stored CTRL fields, laid out to match CTRL bits 8:1
    typedef struct packed {
        logic               irq_en;
        logic [SHIFT_W-1:0] alpha_shift;
        cordic_mode_e       mode;
        logic               is_rotating;
    } ctrl_t;

    // Byte writes only reach CTRL bits 7:0, so irq_en is kept
    function automatic ctrl_t ctrl_merge(input ctrl_t cur, input logic [7:0] wfields,
                                         input logic byte_wr);
        ctrl_t nxt;
        nxt = ctrl_t'(wfields);
        if (byte_wr) nxt.irq_en = cur.irq_en;
        return nxt;
    endfunction

endpackage

// File: rtl/cordic_fe_watchdog.sv
// WAIT-state cycle counter; flags expiry on the LIMIT-th cycle spent in WAIT.
module cordic_fe_watchdog
    import cordic_bus_frontend_pkg::*;
#(
    parameter int unsigned LIMIT = TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired_c
);

    localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign expired_c = run && (cnt == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expired_c) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cordic_bus_frontend.sv
// TinyQV peripheral front end for the iterative CORDIC core.
// Optional WAIT watchdog enabled by defining CORDIC_FE_TIMEOUT_EN.
module cordic_bus_frontend
    import cordic_bus_frontend_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      address,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [1:0]             data_write_n,
    input  logic [1:0]             data_read_n,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_ready,
    output logic                   user_interrupt,
    output logic                   core_start,
    output logic                   core_is_rotating,
    output logic [1:0]             core_mode,
    output logic [SHIFT_W-1:0]     core_alpha_shift,
    output logic [FIXED_WIDTH-1:0] core_a,
    output logic [FIXED_WIDTH-1:0] core_b,
    input  logic [FIXED_WIDTH-1:0] core_out1,
    input  logic [FIXED_WIDTH-1:0] core_out2,
    input  logic                   core_done
);

    fe_state_e              state;
    logic [FIXED_WIDTH-1:0] opa, opb, res1, res2;
    ctrl_t                  ctrl, cfg;
    logic                   result_valid, overrun, irq_pend, timeout_flag, start_q;

    logic                   wr_en_c, wr_byte_c, rd_en_c, go_c, busy_c, wd_expire_c;
    logic [ADDR_W-1:0]      reg_addr_c;
    ctrl_t                  ctrl_wr_c;
    logic                   unused_c;

    assign reg_addr_c = {address[ADDR_W-1:2], 2'b00};
    assign wr_en_c    = (data_write_n != 2'b11);
    assign wr_byte_c  = (data_write_n == 2'b00);
    assign rd_en_c    = (data_read_n != 2'b11);
    assign ctrl_wr_c  = ctrl_merge(ctrl, data_in[CTRL_IRQ_EN:CTRL_ROT], wr_byte_c);
    assign go_c       = wr_en_c && (reg_addr_c == OFS_CTRL) && data_in[CTRL_GO];
    assign busy_c     = (state != ST_IDLE);
    assign unused_c   = &{1'b0, data_in[DATA_W-1:FIXED_WIDTH], address[1:0]};

`ifdef CORDIC_FE_TIMEOUT_EN
    cordic_fe_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == ST_LAUNCH),
        .run       (state == ST_WAIT),
        .expired_c (wd_expire_c)
    );
`else
    assign wd_expire_c = 1'b0;
`endif

    // Register file and sequencer; clears come first so same-cycle set events win
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            opa          <= '0;
            opb          <= '0;
            res1         <= '0;
            res2         <= '0;
            ctrl         <= '0;
            cfg          <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            irq_pend     <= 1'b0;
            timeout_flag <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            start_q <= 1'b0;

            if (wr_en_c) begin
                case (reg_addr_c)
                    OFS_OPA: begin
                        if (wr_byte_c) opa[7:0] <= data_in[7:0];
                        else           opa      <= data_in[FIXED_WIDTH-1:0];
                    end
                    OFS_OPB: begin
                        if (wr_byte_c) opb[7:0] <= data_in[7:0];
                        else           opb      <= data_in[FIXED_WIDTH-1:0];
                    end
                    OFS_CTRL: ctrl <= ctrl_wr_c;
                    OFS_STATUS: begin
                        if (data_in[STAT_OVERRUN])  overrun      <= 1'b0;
                        if (data_in[STAT_IRQ_PEND]) irq_pend     <= 1'b0;
                        if (data_in[STAT_TIMEOUT])  timeout_flag <= 1'b0;
                    end
                    default: ;
                endcase
            end

            if (rd_en_c && (reg_addr_c == OFS_RES2)) result_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (go_c) begin
                        cfg     <= ctrl_wr_c;
                        start_q <= 1'b1;
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state <= ST_WAIT;
                ST_WAIT: begin
                    if (core_done) begin
                        res1         <= core_out1;
                        res2         <= core_out2;
                        result_valid <= 1'b1;
                        if (cfg.irq_en) irq_pend <= 1'b1;
                        state        <= ST_IDLE;
                    end else if (wd_expire_c) begin
                        timeout_flag <= 1'b1;
                        if (cfg.irq_en) irq_pend <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (go_c && busy_c) overrun <= 1'b1;
        end
    end

    // Combinational read-back; zero when no read is in progress
    always_comb begin
        data_out = '0;
        if (rd_en_c) begin
            case (reg_addr_c)
                OFS_OPA:    data_out = DATA_W'(opa);
                OFS_OPB:    data_out = DATA_W'(opb);
                OFS_CTRL:   data_out = DATA_W'({ctrl, 1'b0});
                OFS_STATUS: data_out = DATA_W'({timeout_flag, irq_pend, overrun,
                                                result_valid, busy_c});
                OFS_RES1:   data_out = DATA_W'(res1);
                OFS_RES2:   data_out = DATA_W'(res2);
                default:    data_out = '0;
            endcase
        end
    end

    assign data_ready       = 1'b1;
    assign user_interrupt   = irq_pend;
    assign core_start       = start_q;
    assign core_is_rotating = cfg.is_rotating;
    assign core_mode        = cfg.mode;
    assign core_alpha_shift = cfg.alpha_shift;
    assign core_a           = opa;
    assign core_b           = opb;

endmodule

// File: tb/tb_cordic_bus_frontend.sv
// Self-checking bench for cordic_bus_frontend with a CORDIC core stub
// (out1=A+B, out2=A^B, done 10 cycles after start).
module tb_cordic_bus_frontend;
    import cordic_bus_frontend_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [ADDR_W-1:0]      address = '0;
    logic [DATA_W-1:0]      data_in = '0;
    logic [1:0]             data_write_n = 2'b11;
    logic [1:0]             data_read_n = 2'b11;
    logic [DATA_W-1:0]      data_out;
    logic                   data_ready, user_interrupt, core_start, core_is_rotating;
    logic [1:0]             core_mode;
    logic [SHIFT_W-1:0]     core_alpha_shift;
    logic [FIXED_WIDTH-1:0] core_a, core_b;
    logic [FIXED_WIDTH-1:0] core_out1 = '0;
    logic [FIXED_WIDTH-1:0] core_out2 = '0;
    logic                   core_done = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [15:0] r1;
        logic [15:0] r2;
    } exp_t;
    exp_t        sb_q[$];
    logic [15:0] mdl_opa = '0, mdl_opb = '0;
    logic [15:0] stub_a = '0, stub_b = '0;
    int          stub_cnt = 0;
    int          n_start = 0;
    logic        stub_mute = 1'b0;

    always #5 clk = ~clk;

    cordic_bus_frontend dut (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
        .data_ready(data_ready), .user_interrupt(user_interrupt), .core_start(core_start),
        .core_is_rotating(core_is_rotating), .core_mode(core_mode),
        .core_alpha_shift(core_alpha_shift), .core_a(core_a), .core_b(core_b),
        .core_out1(core_out1), .core_out2(core_out2), .core_done(core_done)
    );

    // Core stub; pushes the expected result from the bench's own operand model
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) begin
            n_start  <= n_start + 1;
            stub_a   <= core_a;
            stub_b   <= core_b;
            stub_cnt <= stub_mute ? 0 : 10;
            sb_q.push_back({16'(mdl_opa + mdl_opb), 16'(mdl_opa ^ mdl_opb)});
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) begin
                core_done <= 1'b1;
                core_out1 <= 16'(stub_a + stub_b);
                core_out2 <= stub_a ^ stub_b;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
        @(negedge clk);
        address = a; data_in = d; data_write_n = wn;
        @(negedge clk);
        data_write_n = 2'b11;
        if ({a[5:2], 2'b00} == OFS_OPA) begin
            if (wn == 2'b00) mdl_opa[7:0] = d[7:0]; else mdl_opa = d[15:0];
        end else if ({a[5:2], 2'b00} == OFS_OPB) begin
            if (wn == 2'b00) mdl_opb[7:0] = d[7:0]; else mdl_opb = d[15:0];
        end
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; data_read_n = 2'b00;
        #1 d = data_out;
        @(negedge clk);
        data_read_n = 2'b11;
    endtask

    task automatic check_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 200; i++) begin
            bus_read(OFS_STATUS, v);
            if (!v[STAT_BUSY]) break;
        end
        check(tag, 32'(v[STAT_BUSY]), 32'h0);
    endtask

    task automatic check_result(input string tag);
        logic [31:0] r1, r2;
        exp_t        e;
        check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        bus_read(OFS_RES1, r1);
        check({tag, "_res1"}, r1, 32'(e.r1));
        bus_read(OFS_RES2, r2);
        check({tag, "_res2"}, r2, 32'(e.r2));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=stalled expected=finish");
        $fatal(1);
    end

    initial begin
        int starts0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_core_start", 32'(core_start), 32'h0);
        check("rst_irq", 32'(user_interrupt), 32'h0);
        check("rst_ready", 32'(data_ready), 32'h1);
        check("rst_dout_idle", data_out, 32'h0);
        check_reg("rst_status", OFS_STATUS, 32'h0);

        // Basic flow
        bus_write(OFS_OPA, 32'h0000_1200, 2'b10);
        bus_write(6'h06, 32'hDEAD_0034, 2'b01);
        check("dout_no_read", data_out, 32'h0);
        bus_write(OFS_CTRL, 32'h0000_0007, 2'b10);
        check("basic_start", 32'(core_start), 32'h1);
        check("basic_core_a", 32'(core_a), 32'h1200);
        check("basic_core_b", 32'(core_b), 32'h0034);
        check("basic_mode", 32'(core_mode), 32'h1);
        check("basic_rot", 32'(core_is_rotating), 32'h1);
        check_reg("basic_status_busy", OFS_STATUS, 32'h1);
        check("basic_start_pulse", 32'(core_start), 32'h0);
        wait_idle("basic_idle");
        check_reg("basic_status_done", OFS_STATUS, 32'h2);
        check_result("basic");
        check_reg("basic_status_rd", OFS_STATUS, 32'h0);
        check("basic_no_irq", 32'(user_interrupt), 32'h0);

        // Overrun
        starts0 = n_start;
        bus_write(OFS_CTRL, 32'h1, 2'b10);
        bus_write(OFS_CTRL, 32'h1, 2'b10);
        check_reg("ovr_status", OFS_STATUS, 32'h5);
        wait_idle("ovr_idle");
        check("ovr_one_start", 32'(n_start - starts0), 32'h1);
        check_reg("ovr_status_done", OFS_STATUS, 32'h6);
        bus_write(OFS_STATUS, 32'h4, 2'b10);
        check_reg("ovr_w1c", OFS_STATUS, 32'h2);
        check_result("ovr");

        // Interrupt, byte write to OPA
        bus_write(OFS_OPA, 32'hFFFF_FFAB, 2'b00);
        check_reg("byte_opa", OFS_OPA, 32'h12AB);
        bus_write(OFS_CTRL, 32'h101, 2'b10);
        wait_idle("irq_idle");
        check("irq_set", 32'(user_interrupt), 32'h1);
        check_reg("irq_status", OFS_STATUS, 32'hA);
        bus_write(OFS_STATUS, 32'h8, 2'b10);
        check("irq_w1c", 32'(user_interrupt), 32'h0);
        check_reg("irq_status_w1c", OFS_STATUS, 32'h2);
        check_result("irq");
        check_reg("irq_status_rd", OFS_STATUS, 32'h0);

        // CTRL readback; byte write keeps irq_en, GO=0 launches nothing
        check_reg("ctrl_rb", OFS_CTRL, 32'h100);
        starts0 = n_start;
        bus_write(OFS_CTRL, 32'h0000_00F6, 2'b00);
        check_reg("ctrl_byte", OFS_CTRL, 32'h1F6);
        check_reg("ctrl_nogo_status", OFS_STATUS, 32'h0);
        check("ctrl_nogo_start", 32'(n_start - starts0), 32'h0);

        // Writes while busy do not disturb the in-flight operation
        bus_write(OFS_CTRL, 32'h0A9, 2'b10);
        check("busy_mode", 32'(core_mode), 32'h2);
        check("busy_shift", 32'(core_alpha_shift), 32'hA);
        bus_write(OFS_OPA, 32'h0000_FFFF, 2'b10);
        bus_write(OFS_CTRL, 32'h0, 2'b10);
        check("busy_cfg_hold", 32'(core_mode), 32'h2);
        wait_idle("busy_idle");
        check_result("busy");
        check_reg("busy_opa_rb", OFS_OPA, 32'hFFFF);

        // Reset while waiting; the late done must be ignored
        bus_write(OFS_CTRL, 32'h101, 2'b10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mdl_opa = '0; mdl_opb = '0;
        sb_q.delete();
        repeat (15) @(negedge clk);
        check_reg("mrst_status", OFS_STATUS, 32'h0);
        check_reg("mrst_res1", OFS_RES1, 32'h0);
        check_reg("mrst_opa", OFS_OPA, 32'h0);
        check("mrst_irq", 32'(user_interrupt), 32'h0);

        // Unmapped addresses
        bus_write(6'h1C, 32'hFFFF_FFFF, 2'b10);
        check_reg("unmapped_18", 6'h18, 32'h0);
        check_reg("unmapped_1c", 6'h1C, 32'h0);

`ifdef CORDIC_FE_TIMEOUT_EN
        // Watchdog expiry with a silent core
        stub_mute = 1'b1;
        bus_write(OFS_CTRL, 32'h101, 2'b10);
        repeat (40) @(negedge clk);
        check_reg("to_still_busy", OFS_STATUS, 32'h1);
        wait_idle("to_idle");
        check_reg("to_status", OFS_STATUS, 32'h18);
        check("to_irq", 32'(user_interrupt), 32'h1);
        sb_q.delete();
        stub_mute = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
